mac_tx_arbiter: RTL

//   Shares one mac_controller transmitter between N_REQ byte requesters with round-robin fairness.
//   Per transfer: latches the winner's byte, pulses tx_req to the MAC and waits for tx_done.

---
 rtl/mac_pkg.sv | 13 +
 rtl/rr_pick.sv | 24 ++
 rtl/mac_tx_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared MAC transmit-path definitions: arbiter state encoding and the MAC byte width.
package mac_pkg;

    localparam int MAC_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr+1, ptr+2, ... (mod N).
module rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] winner
);

    always_comb begin
        logic [PW-1:0] idx;
        any    = |req;
        winner = ptr;
        idx    = '0;
        // Scan from the far end back toward ptr+1 so the nearest candidate is the last one written.
        for (int k = N; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter sharing one MAC transmitter between N_REQ byte requesters.
//   state    | meaning
//   ST_IDLE  | waiting for any request; picks winner, latches byte, pulses mac_tx_req
//   ST_ISSUE | start pulse ends, watchdog cleared
//   ST_WAIT  | waiting for mac_tx_done or watchdog expiry; ack/err pulse on exit
//   ST_GAP   | grant released, inter-frame gap of IFG cycles, requests ignored
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = MAC_DATA_W,
    parameter int TIMEOUT = 64,
    parameter int IFG     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          err,
    output logic                      busy,
    output logic [DATA_W-1:0]         mac_data_in,
    output logic                      mac_tx_req,
    input  logic                      mac_tx_done
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(IFG + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG - 1);

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     owner, owner_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [GW-1:0]     gap, gap_nxt;
    logic [N_REQ-1:0]  grant_nxt, ack_nxt, err_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              tx_req_nxt, busy_nxt;
    logic              pick_any;
    logic [PW-1:0]     pick_idx;

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= PW'(N_REQ - 1);
            owner       <= '0;
            cnt         <= '0;
            gap         <= '0;
            grant       <= '0;
            ack         <= '0;
            err         <= '0;
            busy        <= 1'b0;
            mac_data_in <= '0;
            mac_tx_req  <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            cnt         <= cnt_nxt;
            gap         <= gap_nxt;
            grant       <= grant_nxt;
            ack         <= ack_nxt;
            err         <= err_nxt;
            busy        <= busy_nxt;
            mac_data_in <= data_nxt;
            mac_tx_req  <= tx_req_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        cnt_nxt    = cnt;
        gap_nxt    = gap;
        grant_nxt  = grant;
        ack_nxt    = '0;
        err_nxt    = '0;
        data_nxt   = mac_data_in;
        tx_req_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_nxt  = pick_idx;
                    grant_nxt  = N_REQ'(1) << pick_idx;
                    data_nxt   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    tx_req_nxt = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nxt = cnt + 1'b1;
                // Completion takes precedence over a watchdog expiry on the same edge.
                if (mac_tx_done) begin
                    ack_nxt   = N_REQ'(1) << owner;
                    ptr_nxt   = owner;
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = N_REQ'(1) << owner;
                    ptr_nxt   = owner;
                    gap_nxt   = '0;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                grant_nxt = '0;
                gap_nxt   = gap + 1'b1;
                if (gap == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
